// File: rtl/io_input_sync_if.sv
// Signal bundle between the raw board inputs and the input conditioner.
// The conditioner takes the slave side; stimulus or board glue takes the master side.
interface io_input_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SW_WIDTH   = 18,
  parameter int KEY_WIDTH  = 4
);
  logic [SW_WIDTH-1:0]   sw_i;
  logic [KEY_WIDTH-1:0]  key_ni;
  logic [KEY_WIDTH-1:0]  evt_clr_i;
  logic [DATA_WIDTH-1:0] sw_data_o;
  logic [KEY_WIDTH-1:0]  key_evt_o;

  modport master (
    output sw_i, key_ni, evt_clr_i,
    input  sw_data_o, key_evt_o
  );

  modport slave (
    input  sw_i, key_ni, evt_clr_i,
    output sw_data_o, key_evt_o
  );
endinterface

// File: rtl/io_input_sync.sv
// Switch/key conditioner: 2-flop sync, tick-based per-bit debounce, sticky key-press
// events, packed into a registered word for the LSU input-peripheral bank.
module io_input_sync #(
  parameter int DATA_WIDTH   = 32,
  parameter int SW_WIDTH     = 18,
  parameter int KEY_WIDTH    = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  io_input_sync_if.slave bus
);
  localparam int NB = SW_WIDTH + KEY_WIDTH;
  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [NB-1:0]               raw_s;
  logic [NB-1:0]               meta_q;
  logic [NB-1:0]               sync_q;
  logic [PW-1:0]               pre_q, pre_d;
  logic                        tick_s;
  logic [NB-1:0]               lvl_q, lvl_d;
  logic [NB-1:0][CW-1:0]       cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]        evt_q, evt_d;
  logic [KEY_WIDTH-1:0]        press_s;
  logic [DATA_WIDTH-1:0]       data_q, data_d;

  // Keys are inverted up front so every internal level is active-high.
  assign raw_s = {~bus.key_ni, bus.sw_i};

  // Two-stage synchroniser for all raw inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw_s;
      sync_q <= meta_q;
    end
  end

  // Free-running debounce prescaler.
  always_comb begin
    tick_s = (pre_q == PRE_MAX);
    if (tick_s) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Per-bit debounce: a differing sample must survive STABLE_TICKS ticks in a row.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_s) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = sync_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Sticky press events; a press in the same clock as a clear wins.
  always_comb begin
    press_s = lvl_d[NB-1:SW_WIDTH] & ~lvl_q[NB-1:SW_WIDTH];
    evt_d   = (evt_q & ~bus.evt_clr_i) | press_s;
    data_d  = '0;
    data_d[NB+KEY_WIDTH-1:0] = {evt_d, lvl_d};
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q  <= '0;
      lvl_q  <= '0;
      cnt_q  <= '0;
      evt_q  <= '0;
      data_q <= '0;
    end else begin
      pre_q  <= pre_d;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      evt_q  <= evt_d;
      data_q <= data_d;
    end
  end

  assign bus.sw_data_o = data_q;
  assign bus.key_evt_o = evt_q;
endmodule

// File: tb/tb_io_input_sync.sv
// Directed bench for io_input_sync with TICK_DIV=4, STABLE_TICKS=3: a vector table of
// settled input patterns plus hand sequences for latency, bounce, events and reset.
module tb_io_input_sync;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  io_input_sync_if #(.DATA_WIDTH(32), .SW_WIDTH(18), .KEY_WIDTH(4)) bus ();

  io_input_sync #(
    .DATA_WIDTH(32), .SW_WIDTH(18), .KEY_WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [17:0] sw;
    logic [3:0]  key_n;
    logic [3:0]  clr;
    logic [31:0] exp_data;
    logic [3:0]  exp_evt;
  } vec_t;

  vec_t vecs [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int edge_n);
    checks++;
    if (edge_n < 10 || edge_n > 13) begin
      failures++;
      $display("FAIL %s actual_edge=%0d required=10..13", name, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.sw_i      = 18'h0;
    bus.key_ni    = 4'hF;
    bus.evt_clr_i = 4'h0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits for a sw_data_o bit to rise; edge_n is the edge index counted from 0, -1 if none.
  task automatic wait_bit(input int idx, output int edge_n);
    edge_n = -1;
    for (int k = 0; k < 24; k++) begin
      step();
      if (bus.sw_data_o[idx] == 1'b1) begin
        edge_n = k;
        break;
      end
    end
  endtask

  // Upper pad bits must be zero at every sample point.
  always @(negedge clk) begin
    chk("upper_zero", {26'h0, bus.sw_data_o[31:26]}, 32'h0);
  end

  initial begin
    int e;
    int viol;
    checks   = 0;
    failures = 0;

    vecs[0] = '{18'h2AAAA, 4'hF, 4'h0, 32'h0002AAAA, 4'h0};
    vecs[1] = '{18'h15555, 4'hF, 4'h0, 32'h00015555, 4'h0};
    vecs[2] = '{18'h3FFFF, 4'hE, 4'h0, 32'h0047FFFF, 4'h1};
    vecs[3] = '{18'h00000, 4'hF, 4'h0, 32'h00400000, 4'h1};
    vecs[4] = '{18'h00000, 4'hF, 4'hF, 32'h00000000, 4'h0};
    vecs[5] = '{18'h00001, 4'h6, 4'h0, 32'h02640001, 4'h9};
    vecs[6] = '{18'h20000, 4'h0, 4'h1, 32'h03BE0000, 4'hE};

    // Reset with all inputs active.
    bus.sw_i      = 18'h3FFFF;
    bus.key_ni    = 4'h0;
    bus.evt_clr_i = 4'h0;
    rst = 1'b1;
    #2;
    chk("rst_data_async", bus.sw_data_o, 32'h0);
    step();
    step();
    chk("rst_data", bus.sw_data_o, 32'h0);
    chk("rst_evt", {28'h0, bus.key_evt_o}, 32'h0);
    rst = 1'b0;
    step();
    chk("rst_rel_data", bus.sw_data_o, 32'h0);
    chk("rst_rel_evt", {28'h0, bus.key_evt_o}, 32'h0);

    // Table of settled patterns.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.sw_i      = vecs[i].sw;
      bus.key_ni    = vecs[i].key_n;
      bus.evt_clr_i = vecs[i].clr;
      repeat (16) step();
      chk($sformatf("vec%0d_data", i), bus.sw_data_o, vecs[i].exp_data);
      chk($sformatf("vec%0d_evt", i), {28'h0, bus.key_evt_o}, {28'h0, vecs[i].exp_evt});
    end

    // Clean switch step: latency window then stability.
    do_reset();
    bus.sw_i = 18'h00005;
    e = -1;
    for (int k = 0; k < 24; k++) begin
      step();
      if (bus.sw_data_o[17:0] != 18'h0) begin
        e = k;
        break;
      end
    end
    chk_lat("step_lat", e);
    chk("step_val", {14'h0, bus.sw_data_o[17:0]}, 32'h5);
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.sw_data_o[17:0] != 18'h5) viol++;
    end
    chk("step_stable", viol, 32'h0);

    // Bounce on sw_i[0], then a clean hold.
    do_reset();
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      bus.sw_i[0] = ((i / 3) % 2 == 0);
      step();
      if (bus.sw_data_o[0] != 1'b0) viol++;
    end
    chk("bounce_hold", viol, 32'h0);
    bus.sw_i[0] = 1'b1;
    wait_bit(0, e);
    chk_lat("bounce_lat", e);

    // Key press event and release.
    do_reset();
    bus.key_ni = 4'b1011;
    wait_bit(20, e);
    chk_lat("key_lat", e);
    chk("key_evt_bit", {31'h0, bus.sw_data_o[24]}, 32'h1);
    chk("key_evt_o", {28'h0, bus.key_evt_o}, 32'h4);
    bus.key_ni = 4'hF;
    repeat (16) step();
    chk("rel_level", {31'h0, bus.sw_data_o[20]}, 32'h0);
    chk("rel_evt", {28'h0, bus.key_evt_o}, 32'h4);
    chk("rel_evt_bit", {31'h0, bus.sw_data_o[24]}, 32'h1);

    // Clear held across the accepting clock: set wins.
    do_reset();
    bus.evt_clr_i = 4'b0010;
    bus.key_ni    = 4'b1101;
    wait_bit(19, e);
    chk_lat("coll_lat", e);
    chk("coll_set_wins", {28'h0, bus.key_evt_o}, 32'h2);
    bus.evt_clr_i = 4'h0;
    step();
    chk("coll_after", {28'h0, bus.key_evt_o}, 32'h2);
    bus.evt_clr_i = 4'b0010;
    step();
    bus.evt_clr_i = 4'h0;
    chk("clr_pulse", {28'h0, bus.key_evt_o}, 32'h0);

    // Reset mid-debounce discards partial progress.
    do_reset();
    bus.sw_i = 18'h00008;
    repeat (6) step();
    rst = 1'b1;
    step();
    chk("mid_rst_bit3", {31'h0, bus.sw_data_o[3]}, 32'h0);
    rst = 1'b0;
    wait_bit(3, e);
    chk_lat("mid_rst_lat", e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_input_sync.md
# io_input_sync

Input conditioner that sits directly upstream of the load/store unit's input-peripheral bank. It synchronises the raw board switches and push-buttons, debounces every bit against a shared millisecond-class tick, and latches sticky key-press events. The resulting word drives the LSU `sw_data_i` input, so software reads clean, stable values at the input-peripheral addresses.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the output word. Must be ≥ `SW_WIDTH + 2*KEY_WIDTH`.
- `SW_WIDTH`, 18: number of slide switches.
- `KEY_WIDTH`, 4: number of push-buttons.
- `TICK_DIV`, 50000: clocks per debounce tick. Must be ≥ 2.
- `STABLE_TICKS`, 4: number of consecutive ticks a new level must persist before it is accepted. Must be ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `sw_i` in `SW_WIDTH`: raw switches, active-high, asynchronous to `clk_i`.
- `key_ni` in `KEY_WIDTH`: raw push-buttons, active-low (0 = pressed), asynchronous.
- `evt_clr_i` in `KEY_WIDTH`: per-key event clear, sampled each clock.
- `sw_data_o` out `DATA_WIDTH`: conditioned word feeding the LSU `sw_data_i`.
- `key_evt_o` out `KEY_WIDTH`: copy of the sticky event bits.

## Operation
- **Inversion.** Keys are inverted at the input (`p = ~key_ni`), so all internal levels are active-high.
- **Synchronisation.** Every switch bit and every inverted key bit passes through a 2-flop synchroniser. The second stage is the sample `y`.
- **Prescaler.** A free-running counter runs 0..`TICK_DIV`-1. `tick` = (count == `TICK_DIV`-1). The counter wraps to 0 on the next clock.
- **Per-bit debouncer** (state: accepted level `s`, counter `c` of width `clog2(STABLE_TICKS)+1`):
  - If `y == s`: `c <= 0` on that clock, whether or not `tick` is high.
  - Else if `tick` and `c == STABLE_TICKS-1`: `s <= y`, `c <= 0`.
  - Else if `tick`: `c <= c + 1`.
  - Otherwise: hold.
  - Any bounce back to `s` restarts the count.
- **Events.** Key event bit `e[k]` is set on the clock where `s_key[k]` goes 0→1, i.e. an accepted press.
  - `e[k]` clears when `evt_clr_i[k]` = 1.
  - If set and clear occur in the same clock, set wins.
  - Releases never set an event.
- **Output packing** (all fields registered; no combinational path from any input):
  - `[SW_WIDTH-1:0]` = `s_sw`
  - `[SW_WIDTH+KEY_WIDTH-1:SW_WIDTH]` = `s_key`
  - `[SW_WIDTH+2*KEY_WIDTH-1:SW_WIDTH+KEY_WIDTH]` = `e`
  - remaining upper bits = 0
- `key_evt_o` = `e`.

## Timing
- **Reset values** (asynchronous on `rst_i` = 1):
  - synchroniser flops = 0, i.e. switches off and keys released
  - prescaler = 0
  - every `s`, `c` and `e` = 0
  - `sw_data_o` = 0, `key_evt_o` = 0
- Reset asserted mid-debounce discards all partial counts. After release, the prescaler restarts at 0, and the first `tick` occurs `TICK_DIV` clocks later.
- **Input latency.** Take a clean input step that is set up before edge 0. `y` changes after edge 1. `s` (and `sw_data_o`) changes at an edge between edge 2+(`STABLE_TICKS`-1)·`TICK_DIV` and edge 1+`STABLE_TICKS`·`TICK_DIV`, inclusive; the exact edge depends on prescaler phase.
- An event bit becomes visible on the same edge as the `s_key` rise that causes it.
- **Event clear latency.** A clear pulse asserted for one clock takes effect on the next edge.
- **Glitch rejection.** A pulse shorter than (`STABLE_TICKS`-1)·`TICK_DIV` clocks never changes `s`.
- **Simultaneous changes.** Independent bits are fully independent; simultaneous changes on several bits may be accepted on the same edge.

## Test plan
Bench parameters: `TICK_DIV`=4, `STABLE_TICKS`=3.
- **Reset.** Assert `rst_i` with `sw_i`=18'h3FFFF and `key_ni`=4'h0. Require `sw_data_o`=0 and `key_evt_o`=0 during reset and on the first clock after release.
- **Clean switch step.** `sw_i` goes 0→18'h00005 and holds. Require `sw_data_o`[17:0]=18'h00005 at an edge within 10..13 clocks after the change, never earlier, and stable thereafter.
- **Bounce.** `sw_i[0]` toggles every 3 clocks for 40 clocks, then holds 1. Require bit 0 to stay 0 throughout the toggling, then rise within 10..13 clocks after the final hold.
- **Key press event.** `key_ni[2]` goes 1→0 and holds. Require `sw_data_o`[20]=1 and `sw_data_o`[24]=1 and `key_evt_o`=4'b0100 on the same edge. Release the key: the event must stay 1 and bit 20 must go to 0.
- **Clear versus set collision.** Hold `evt_clr_i[1]`=1 during the clock where `key_ni[1]`'s press is accepted. Require `key_evt_o[1]`=1 afterward. A later one-clock clear must drive it to 0 on the next edge.
- **Reset mid-debounce.** Apply a `sw_i[3]` step, then pulse `rst_i` 6 clocks later. Require bit 3=0 after reset, then acceptance 10..13 clocks after reset release, counted from prescaler 0. Require upper bits [31:26]=0 at all times.
